// File: rtl/pwm_duty_ctrl.sv
// PWM generator with a run-time programmable period and high time.
// Config updates are staged in a one-deep slot and applied only at period boundaries.
module pwm_duty_ctrl #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DEF_PERIOD = 4,
    parameter int unsigned DEF_HIGH   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             pwm_out,
    output logic             period_done,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] per, per_nxt;
    logic [CNT_W-1:0] high, high_nxt;
    logic             pend_full, pend_full_nxt;
    logic [CNT_W-1:0] pend_per, pend_per_nxt;
    logic [CNT_W-1:0] pend_high, pend_high_nxt;
    logic             pwm_nxt;
    logic             done_nxt;
    logic             err_nxt;
    logic             accept;
    logic             cfg_ok;
    logic             last;

    assign cfg_ready = !pend_full;
    assign busy      = (state == RUN);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        per_nxt       = per;
        high_nxt      = high;
        pend_full_nxt = pend_full;
        pend_per_nxt  = pend_per;
        pend_high_nxt = pend_high;

        accept  = cfg_valid && !pend_full;
        cfg_ok  = (cfg_period != '0);
        last    = (cnt == per - CNT_W'(1));
        err_nxt = accept && !cfg_ok;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (accept && cfg_ok) begin
                    per_nxt  = cfg_period;
                    high_nxt = cfg_high;
                end
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    cnt_nxt = '0;
                    if (pend_full) begin
                        per_nxt       = pend_per;
                        high_nxt      = pend_high;
                        pend_full_nxt = 1'b0;
                    end
                    if (!en) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                // accept implies the slot was empty, so this never races the boundary load above
                if (accept && cfg_ok) begin
                    pend_full_nxt = 1'b1;
                    pend_per_nxt  = cfg_period;
                    pend_high_nxt = cfg_high;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Outputs are registered against the post-edge count and active config.
        pwm_nxt  = (state_nxt == RUN) && (cnt_nxt < high_nxt);
        done_nxt = (state_nxt == RUN) && (cnt_nxt == per_nxt - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            per         <= CNT_W'(DEF_PERIOD);
            high        <= CNT_W'(DEF_HIGH);
            pend_full   <= 1'b0;
            pend_per    <= '0;
            pend_high   <= '0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            per         <= per_nxt;
            high        <= high_nxt;
            pend_full   <= pend_full_nxt;
            pend_per    <= pend_per_nxt;
            pend_high   <= pend_high_nxt;
            pwm_out     <= pwm_nxt;
            period_done <= done_nxt;
            cfg_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl: directed vectors push hand-computed outputs,
// a negedge monitor pops and compares {pwm_out, period_done, busy, cfg_ready, cfg_err}.
module tb_pwm_duty_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_period;
    logic [7:0] cfg_high;
    logic       cfg_ready;
    logic       cfg_err;
    logic       pwm_out;
    logic       period_done;
    logic       busy;

    typedef struct {
        string      name;
        logic [4:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   vectors_applied;
    int   miscompares;
    bit   stim_done;

    pwm_duty_ctrl #(
        .CNT_W     (8),
        .DEF_PERIOD(4),
        .DEF_HIGH  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .pwm_out    (pwm_out),
        .period_done(period_done),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs for one edge, then queue the outputs expected after that edge.
    task automatic step(input logic r, input logic e, input logic v,
                        input logic [7:0] p, input logic [7:0] h,
                        input logic [4:0] x, input string nm);
        exp_t item;
        rst        = r;
        en         = e;
        cfg_valid  = v;
        cfg_period = p;
        cfg_high   = h;
        @(posedge clk);
        #1;
        item.name = nm;
        item.val  = x;
        exp_q.push_back(item);
    endtask

    // Bits: {pwm_out, period_done, busy, cfg_ready, cfg_err}
    initial begin : monitor
        exp_t       item;
        logic [4:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                got  = {pwm_out, period_done, busy, cfg_ready, cfg_err};
                vectors_applied++;
                if (got !== item.val) begin
                    miscompares++;
                    $display("FAIL %s: got pwm/done/busy/rdy/err=%b expected %b at %0t",
                             item.name, got, item.val, $time);
                end
            end
        end
    end

    initial begin : stimulus
        vectors_applied = 0;
        miscompares     = 0;
        stim_done       = 1'b0;
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;

        // Reset and default 75% pattern
        step(1, 0, 0, 0, 0, 5'b00010, "reset0");
        step(1, 0, 0, 0, 0, 5'b00010, "reset1");
        for (int i = 0; i < 8; i++)
            step(0, 1, 0, 0, 0, (i % 4 == 3) ? 5'b01110 : 5'b10110, "default_75");

        // Mid-period config P=8,H=2 is deferred to the next boundary
        step(0, 1, 0, 0, 0, 5'b10110, "p4_cnt0");
        step(0, 1, 1, 8, 2, 5'b10100, "p4_cnt1_accept");
        step(0, 1, 0, 0, 0, 5'b10100, "p4_cnt2_pending");
        step(0, 1, 0, 0, 0, 5'b01100, "p4_cnt3_done");
        step(0, 1, 0, 0, 0, 5'b10110, "p8_cnt0");
        step(0, 1, 0, 0, 0, 5'b10110, "p8_cnt1");
        step(0, 1, 1, 4, 3, 5'b00100, "p8_cnt2_accept");
        for (int i = 3; i < 7; i++)
            step(0, 1, 0, 0, 0, 5'b00100, "p8_low");
        step(0, 1, 0, 0, 0, 5'b01100, "p8_cnt7_done");

        // Graceful stop: en drops at cnt=1
        step(0, 1, 0, 0, 0, 5'b10110, "stop_cnt0");
        step(0, 1, 0, 0, 0, 5'b10110, "stop_cnt1");
        step(0, 0, 0, 0, 0, 5'b10110, "stop_cnt2");
        step(0, 0, 0, 0, 0, 5'b01110, "stop_cnt3_done");
        step(0, 0, 0, 0, 0, 5'b00010, "stop_idle0");
        step(0, 0, 0, 0, 0, 5'b00010, "stop_idle1");

        // H=0 loaded directly in IDLE, then H=9 via pending
        step(0, 0, 1, 5, 0, 5'b00010, "idle_cfg_p5h0");
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 0, 0, 5'b00110, "h0_low");
        step(0, 1, 0, 0, 0, 5'b01110, "h0_done");
        step(0, 1, 0, 0, 0, 5'b00110, "h0_cnt0");
        step(0, 1, 1, 5, 9, 5'b00100, "h0_accept_h9");
        step(0, 1, 0, 0, 0, 5'b00100, "h0_pend_cnt2");
        step(0, 1, 0, 0, 0, 5'b00100, "h0_pend_cnt3");
        step(0, 1, 0, 0, 0, 5'b01100, "h0_pend_done");
        step(0, 1, 0, 0, 0, 5'b10110, "h9_cnt0");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 5'b10110, "h9_high");
        step(0, 0, 0, 0, 0, 5'b11110, "h9_done");
        step(0, 0, 0, 0, 0, 5'b00010, "h9_idle");

        // P=1,H=1 taken on the IDLE->RUN edge; then cfg_period=0 rejected
        step(0, 1, 1, 1, 1, 5'b11110, "p1_start");
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 0, 0, 5'b11110, "p1_run");
        step(0, 1, 1, 0, 0, 5'b11111, "p0_err");
        step(0, 1, 0, 0, 0, 5'b11110, "p0_after");
        step(0, 1, 0, 0, 0, 5'b11110, "p0_after2");

        // Config on a boundary edge waits one period; then reset with pending held at cnt=2
        step(0, 1, 1, 4, 3, 5'b11100, "p1_boundary_accept");
        step(0, 1, 0, 0, 0, 5'b10110, "p4_load_cnt0");
        step(0, 1, 0, 0, 0, 5'b10110, "p4_load_cnt1");
        step(0, 1, 1, 8, 2, 5'b10100, "pend_cnt2");
        step(1, 0, 0, 0, 0, 5'b00010, "mid_reset");
        for (int i = 0; i < 8; i++)
            step(0, 1, 0, 0, 0, (i % 4 == 3) ? 5'b01110 : 5'b10110, "post_reset_75");

        en = 1'b0;
        stim_done = 1'b1;
    end

    initial begin : finisher
        wait (stim_done);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked vectors expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1);
    end

endmodule
